// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: drives one column at a time, synchronises the row
// inputs, debounces a single press and release, and hands each press to the
// consumer as one key code over a valid/ready handshake.
module keypad_scan_ctrl #(
  parameter int unsigned NROWS           = 4,
  parameter int unsigned NCOLS           = 4,
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  localparam int unsigned CODEW          = $clog2(NROWS * NCOLS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NROWS-1:0] rows_i,
  output logic [NCOLS-1:0] cols_o,
  output logic [CODEW-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             key_held,
  output logic             overrun
);

  localparam int unsigned CW = $clog2(NCOLS);
  localparam int unsigned RW = $clog2(NROWS);
  localparam int unsigned SW = $clog2(SETTLE_CYCLES);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);

  localparam logic [CW-1:0] ColLast    = CW'(NCOLS - 1);
  localparam logic [SW-1:0] SettleLast = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DebLast    = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StScan, StDebounce, StHold} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [DW-1:0]    deb_q, deb_d;
  logic             held_d;
  logic [NROWS-1:0] rows_m, rows_s;
  logic [RW-1:0]    low_row;
  logic             event_fire;
  logic [CODEW-1:0] code_new;

  // Two-flop synchroniser for the asynchronous row lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rows_m <= '0;
      rows_s <= '0;
    end else begin
      rows_m <= rows_i;
      rows_s <= rows_m;
    end
  end

  // Lowest set row index wins when several rows are active on one column.
  always_comb begin
    low_row = '0;
    for (int i = int'(NROWS) - 1; i >= 0; i--) begin
      if (rows_s[i]) low_row = RW'(i);
    end
  end

  assign code_new = CODEW'(row_q) * CODEW'(NCOLS) + CODEW'(col_q);

  // Scan / debounce / hold next-state logic.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    settle_d   = settle_q;
    deb_d      = deb_q;
    held_d     = key_held;
    event_fire = 1'b0;
    unique case (state_q)
      StScan: begin
        if (settle_q == SettleLast) begin
          settle_d = '0;
          if (|rows_s) begin
            row_d   = low_row;
            deb_d   = '0;
            state_d = StDebounce;
          end else begin
            col_d = (col_q == ColLast) ? '0 : col_q + CW'(1);
          end
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      StDebounce: begin
        if (!rows_s[row_q]) begin
          // Bounce: rescan the same column from a fresh settle period.
          state_d  = StScan;
          settle_d = '0;
        end else if (deb_q == DebLast) begin
          state_d    = StHold;
          deb_d      = '0;
          held_d     = 1'b1;
          event_fire = 1'b1;
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end
      StHold: begin
        if (rows_s[row_q]) begin
          deb_d = '0;
        end else if (deb_q == DebLast) begin
          // Release restarts the sweep at column 0 so priority is repeatable.
          state_d  = StScan;
          col_d    = '0;
          settle_d = '0;
          deb_d    = '0;
          held_d   = 1'b0;
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end
      default: state_d = StScan;
    endcase
  end

  // FSM state, counters and registered column drive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StScan;
      col_q    <= '0;
      row_q    <= '0;
      settle_q <= '0;
      deb_q    <= '0;
      key_held <= 1'b0;
      cols_o   <= NCOLS'(1);
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      settle_q <= settle_d;
      deb_q    <= deb_d;
      key_held <= held_d;
      cols_o   <= NCOLS'(1) << col_d;
    end
  end

  // Event handshake: a new event overwrites an unaccepted one and flags overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (event_fire) begin
        key_code  <= code_new;
        key_valid <= 1'b1;
        overrun   <= key_valid & ~key_ready;
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a physical key-matrix model drives the rows,
// directed scenarios plus randomized presses push expected key codes into a
// queue, and a monitor pops and compares on every accepted handshake.
module tb_keypad_scan_ctrl;

  localparam int NR = 4;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NR-1:0] rows_i;
  logic [NC-1:0] cols_o;
  logic [3:0]    key_code;
  logic          key_valid;
  logic          key_ready;
  logic          key_held;
  logic          overrun;

  logic [NR*NC-1:0] pressed;
  logic [NR-1:0]    glitch;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int ovr_seen = 0;
  int ovr_exp  = 0;
  logic ovr_prev = 1'b0;

  logic [NC-1:0] prev_cols;
  int run, n, valid_seen, held_seen, d_ovr;
  int rc, rr1, rr2, hold_len;

  keypad_scan_ctrl #(
    .NROWS(4),
    .NCOLS(4),
    .SETTLE_CYCLES(4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rows_i(rows_i),
    .cols_o(cols_o),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_held(key_held),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Key matrix: a row is high when any pressed key on a driven column shorts it.
  always_comb begin
    rows_i = glitch;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        if (pressed[r*NC+c] && cols_o[c]) rows_i[r] = 1'b1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_held(input logic v, input string name);
    int k;
    k = 0;
    while (key_held !== v && k < 200) begin
      step();
      k++;
    end
    check(name, int'(key_held), int'(v));
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (key_valid !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    check(name, int'(key_valid), 1);
  endtask

  // Monitor: handshake completes on the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (reset_n) begin
      if (overrun) begin
        ovr_seen++;
        check("overrun_one_cycle", int'(ovr_prev), 0);
      end
      ovr_prev = overrun;
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) check("unexpected_event_code", int'(key_code), -1);
        else check("event_code", int'(key_code), exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    key_ready = 1'b0;
    pressed   = '0;
    glitch    = '0;
    repeat (3) step();

    // Reset values.
    check("reset_cols", int'(cols_o), 1);
    check("reset_code", int'(key_code), 0);
    check("reset_valid", int'(key_valid), 0);
    check("reset_held", int'(key_held), 0);
    check("reset_overrun", int'(overrun), 0);
    reset_n = 1'b1;

    // Idle sweep: one-hot rotation, 4 cycles per column, no events.
    prev_cols  = cols_o;
    run        = 0;
    valid_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      run++;
      if (key_valid) valid_seen++;
      if (cols_o != prev_cols) begin
        check("sweep_next_col", int'(cols_o), int'({prev_cols[NC-2:0], prev_cols[NC-1]}));
        check("sweep_dwell", run, 4);
        prev_cols = cols_o;
        run = 0;
      end
    end
    check("idle_no_valid", valid_seen, 0);

    // Key (2,1) -> code 9; handshake, no repeat while held.
    exp_q.push_back(9);
    pressed[9] = 1'b1;
    wait_valid("k9_valid");
    check("k9_code", int'(key_code), 9);
    check("k9_held", int'(key_held), 1);
    key_ready = 1'b1;
    step();
    check("k9_valid_clear", int'(key_valid), 0);
    repeat (40) step();
    pressed[9] = 1'b0;
    n = 0;
    while (key_held && n < 50) begin
      step();
      n++;
    end
    check("clean_release_cycles", n, 10);

    // Release with a 1-cycle bounce: counted from the final release it takes as long.
    exp_q.push_back(9);
    pressed[9] = 1'b1;
    wait_held(1'b1, "bounce_press_held");
    repeat (20) step();
    pressed[9] = 1'b0;
    repeat (4) step();
    pressed[9] = 1'b1;
    step();
    pressed[9] = 1'b0;
    n = 0;
    while (key_held && n < 50) begin
      step();
      n++;
    end
    check("bounce_release_cycles", n, 10);

    // 3-cycle glitch on row 0 during column 3: no event, column 3 settles again.
    n = 0;
    while (cols_o != 4'b1000 && n < 50) begin
      step();
      n++;
    end
    check("glitch_on_col3", int'(cols_o), 8);
    glitch[0] = 1'b1;
    repeat (3) step();
    glitch[0] = 1'b0;
    n = 0;
    held_seen = 0;
    while (cols_o == 4'b1000 && n < 50) begin
      step();
      n++;
      if (key_held) held_seen++;
    end
    check("glitch_next_col0", int'(cols_o), 1);
    check("glitch_no_hold", held_seen, 0);
    check("glitch_col3_resettled", int'(n > 4), 1);

    // Rows 0 and 3 on column 2 through reset release -> lowest row, code 2.
    reset_n = 1'b0;
    exp_q.delete();
    pressed = '0;
    pressed[2] = 1'b1;
    pressed[14] = 1'b1;
    repeat (3) step();
    reset_n = 1'b1;
    exp_q.push_back(2);
    wait_held(1'b1, "prio_row_held");
    check("prio_row_code", int'(key_code), 2);
    pressed = '0;
    wait_held(1'b0, "prio_row_release");

    // Keys (1,0) and (1,3) through reset release -> first column in sweep, code 4.
    reset_n = 1'b0;
    exp_q.delete();
    pressed[4] = 1'b1;
    pressed[7] = 1'b1;
    repeat (3) step();
    reset_n = 1'b1;
    exp_q.push_back(4);
    wait_held(1'b1, "prio_col_held");
    check("prio_col_code", int'(key_code), 4);
    pressed = '0;
    wait_held(1'b0, "prio_col_release");

    // Overrun: (0,0) left unaccepted, then (3,3) overwrites it.
    key_ready = 1'b0;
    pressed[0] = 1'b1;
    wait_valid("ovr1_first_valid");
    pressed[0] = 1'b0;
    wait_held(1'b0, "ovr1_first_release");
    pressed[15] = 1'b1;
    n = 0;
    while (!key_held && n < 200) begin
      step();
      n++;
    end
    d_ovr = n;
    exp_q.push_back(15);
    ovr_exp++;
    check("ovr1_code", int'(key_code), 15);
    check("ovr1_valid", int'(key_valid), 1);
    check("ovr1_pulse", int'(overrun), 1);
    step();
    check("ovr1_pulse_end", int'(overrun), 0);
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    pressed = '0;
    wait_held(1'b0, "ovr1_release");

    // Same sequence, but key_ready=1 on the completing edge: no overrun.
    exp_q.push_back(0);
    pressed[0] = 1'b1;
    wait_valid("ovr2_first_valid");
    pressed[0] = 1'b0;
    wait_held(1'b0, "ovr2_first_release");
    pressed[15] = 1'b1;
    exp_q.push_back(15);
    repeat (d_ovr - 1) step();
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
    check("ovr2_no_pulse", int'(overrun), 0);
    check("ovr2_code", int'(key_code), 15);
    check("ovr2_valid", int'(key_valid), 1);
    check("ovr2_held", int'(key_held), 1);
    key_ready = 1'b1;
    step();
    pressed = '0;
    wait_held(1'b0, "ovr2_release");

    // Reset during HOLD drops the event; the still-held key is reported once.
    key_ready = 1'b0;
    pressed[6] = 1'b1;
    wait_valid("rst_hold_valid");
    reset_n = 1'b0;
    #1;
    check("rst_hold_cols", int'(cols_o), 1);
    check("rst_hold_valid_drop", int'(key_valid), 0);
    check("rst_hold_held_drop", int'(key_held), 0);
    repeat (2) step();
    reset_n = 1'b1;
    exp_q.push_back(6);
    key_ready = 1'b1;
    wait_held(1'b1, "rst_redetect_held");
    repeat (40) step();
    pressed = '0;
    wait_held(1'b0, "rst_redetect_release");

    // Random presses: one key, or two keys in one column (lower row wins).
    for (int it = 0; it < 16; it++) begin
      rc  = int'($urandom_range(3));
      rr1 = int'($urandom_range(3));
      rr2 = rr1;
      pressed = '0;
      pressed[rr1*NC+rc] = 1'b1;
      if ($urandom_range(2) == 0) begin
        rr2 = (rr1 + 1 + int'($urandom_range(2))) % NR;
        pressed[rr2*NC+rc] = 1'b1;
      end
      exp_q.push_back(((rr1 < rr2) ? rr1 : rr2) * NC + rc);
      hold_len = 40 + int'($urandom_range(40));
      for (int k = 0; k < hold_len; k++) begin
        key_ready = 1'($urandom_range(1));
        step();
      end
      check("rand_held", int'(key_held), 1);
      pressed = '0;
      key_ready = 1'b1;
      wait_held(1'b0, "rand_release");
      repeat ($urandom_range(8)) step();
    end

    key_ready = 1'b1;
    repeat (5) step();
    check("queue_drained", exp_q.size(), 0);
    check("overrun_count", ovr_seen, ovr_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Parametrised matrix-keypad scanner that drives the column lines, samples the row lines, debounces a single press and delivers one key code per press. It replaces purely combinational row/column decoding with scanning, synchronisation, debounce and a ready/valid handshake. It sits between the keypad I/O pins and the hex-entry or display logic.

## Interface

Parameters:
- NROWS, 4, number of row lines (≥2)
- NCOLS, 4, number of column lines (≥2)
- SETTLE_CYCLES, 4, cycles each column is driven before rows are sampled (≥3, covers the synchroniser)
- DEBOUNCE_CYCLES, 8, consecutive stable samples required for press and for release (≥2)
- Derived: CODEW = $clog2(NROWS*NCOLS)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- rows_i  in  NROWS  raw row inputs, active-high, asynchronous to clk
- cols_o  out  NCOLS  column drive, one-hot, active-high
- key_code  out  CODEW  key index = row*NCOLS + col
- key_valid  out  1  event pending
- key_ready  in  1  consumer accepts event
- key_held  out  1  debounced key currently down
- overrun  out  1  one-cycle pulse: event lost

## Operation

- rows_i passes through a 2-flop synchroniser; all decisions use rows_s.
- States: SCAN, DEBOUNCE, HOLD.
- SCAN: drive column c; settle counter counts 0..SETTLE_CYCLES-1. On the last count, sample rows_s.
  - If any bit is set, latch r = lowest set row index, keep c, and go to DEBOUNCE.
  - Otherwise advance c (NCOLS-1 wraps to 0) and restart the settle count.
- DEBOUNCE: cols_o stays on c. Each cycle rows_s[r]=1 increments the debounce counter.
  - Any rows_s[r]=0 returns to SCAN on the same column with the settle count restarted.
  - After DEBOUNCE_CYCLES consecutive highs, go to HOLD, load key_code = r*NCOLS+c, set key_valid=1 and key_held=1.
- HOLD: cols_o stays on c. Count consecutive cycles with rows_s[r]=0; any high resets the count.
  - At DEBOUNCE_CYCLES consecutive lows, clear key_held and go to SCAN at column 0.
- Handshake:
  - key_valid stays high, with key_code stable, until sampled with key_ready=1 on a clock edge. It clears on the following cycle.
  - key_ready is ignored while key_valid=0.
  - key_valid does not block scanning.
- Overrun: a new event completing while key_valid=1 and key_ready=0 overwrites key_code, keeps key_valid=1 and pulses overrun for one cycle.
  - If key_ready=1 in that same cycle, the old event is accepted, the new one loads, and overrun stays 0.
- Priority:
  - Within a sample, the lowest row wins.
  - Across columns, the column reached first in the sweep wins. The sweep restarts at column 0 after reset and after every release.
- Keys other than (r,c) are ignored while in DEBOUNCE or HOLD.

## Timing

- Reset values (asynchronous): state SCAN, c=0, cols_o=1 (column 0), key_code=0, key_valid=0, key_held=0, overrun=0, synchroniser and all counters 0.
- Asserting reset mid-press or mid-handshake drops any pending event.
- Minimum press-to-valid latency, for a key on the current column already stable: 2 sync cycles + remaining settle cycles + DEBOUNCE_CYCLES.
- Worst case adds (NCOLS-1)*SETTLE_CYCLES.
- Full sweep period with no key pressed: NCOLS*SETTLE_CYCLES cycles.
- Release-to-scan: 2 + DEBOUNCE_CYCLES cycles after rows_i[r] falls. cols_o changes to column 0 on that same edge.
- Counter widths: $clog2 of each maximum count. Counters must not wrap inside a state.
- All outputs are registered. There are no combinational paths from rows_i or key_ready to any output.

## Test plan

Defaults throughout (4x4, SETTLE=4, DEBOUNCE=8).

- Reset, no keys: cols_o cycles 0001→0010→0100→1000→0001 every 4 cycles; key_valid stays 0.
- Hold row 2 when column 1 is driven, steady: after debounce, key_code=9, key_valid=1, key_held=1; key_ready=1 → key_valid=0 next cycle; holding the key produces no second event.
- 3-cycle glitch on row 0 during column 3 → no event, scan resumes on column 3. A 1-cycle bounce during release delays the return to SCAN by restarting the 8-cycle count.
- Rows 0 and 3 both high on column 2, held through reset release → key_code=2 (lowest row). Keys at (1,0) and (1,3) held through reset release → key_code=4 (column 0 first).
- key_ready=0; press and release (0,0), then press (3,3) → key_code=15, key_valid=1, one overrun pulse. Repeat with key_ready=1 at the completion edge → no overrun pulse.
- Assert reset_n=0 during HOLD → immediately cols_o=0001, key_valid=0, key_held=0; after reset release the key still held is re-detected and reported once.
